// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I R / I-ALU / load / store datapath.
// Moore controls are registered from the next-state decode; only IR/PC write follow mem_ready_i.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             alusrc_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             regwrite_o,
    output logic             memtoreg_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CL_R  = 2'd0,
        CL_I  = 2'd1,
        CL_LD = 2'd2,
        CL_ST = 2'd3
    } class_t;

    // Returns {legal, class}; unsupported opcodes report legal = 0.
    function automatic logic [2:0] decode_class(input logic [6:0] op);
        logic [2:0] res;
        case (op)
            OP_R:    res = {1'b1, CL_R};
            OP_I:    res = {1'b1, CL_I};
            OP_LD:   res = {1'b1, CL_LD};
            OP_ST:   res = {1'b1, CL_ST};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Returns {mem_req, iord, alusrc, memread, memwrite, regwrite, memtoreg, busy}.
    function automatic logic [7:0] moore_ctrl(input state_t st, input class_t cls);
        logic [7:0] c;
        case (st)
            ST_IDLE:   c = 8'b0000_0000;
            ST_FETCH:  c = 8'b1001_0001;
            ST_DECODE: c = 8'b0000_0001;
            ST_EXEC:   c = {2'b00, (cls != CL_R), 4'b0000, 1'b1};
            ST_MEM:    c = {3'b111, (cls == CL_LD), (cls == CL_ST), 2'b00, 1'b1};
            ST_WB:     c = {5'b00000, 1'b1, (cls == CL_LD), 1'b1};
            ST_TRAP:   c = 8'b0000_0000;
            default:   c = 8'b0000_0000;
        endcase
        return c;
    endfunction

    state_t            r_state;
    class_t            r_class;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    logic              r_illegal;
    logic              r_timeout;
    logic              r_mem_req;
    logic              r_iord;
    logic              r_alusrc;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_busy;

    state_t            w_state_nxt;
    class_t            w_class_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_retire;
    logic              w_set_illegal;
    logic              w_set_timeout;
    logic              w_wait_expired;
    logic [2:0]        w_dec;

    assign w_dec          = decode_class(opcode_i);
    assign w_wait_expired = (r_wait == WAIT_LAST) && !mem_ready_i;

    // Next-state, class latch, wait counter and retire/trap events.
    always_comb begin
        w_state_nxt   = r_state;
        w_class_nxt   = r_class;
        w_wait_nxt    = '0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_i) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ready_i) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_wait_expired) begin
                    w_state_nxt   = ST_TRAP;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (w_dec[2]) begin
                    w_class_nxt = class_t'(w_dec[1:0]);
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt   = ST_TRAP;
                    w_set_illegal = 1'b1;
                end
            end
            ST_EXEC: begin
                if ((r_class == CL_LD) || (r_class == CL_ST)) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    if (r_class == CL_LD) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        // Stores retire straight out of MEM, skipping writeback.
                        w_retire    = 1'b1;
                        w_state_nxt = run_i ? ST_FETCH : ST_IDLE;
                    end
                end else if (w_wait_expired) begin
                    w_state_nxt   = ST_TRAP;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            ST_WB: begin
                w_retire    = 1'b1;
                w_state_nxt = run_i ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                w_state_nxt = ST_TRAP;
            end
            default: begin
                w_state_nxt = ST_TRAP;
            end
        endcase
    end

    // State, sticky flags, retire counter and registered Moore controls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_class    <= CL_R;
            r_wait     <= '0;
            r_instret  <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_iord     <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_class   <= w_class_nxt;
            r_wait    <= w_wait_nxt;
            r_illegal <= r_illegal | w_set_illegal;
            r_timeout <= r_timeout | w_set_timeout;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            {r_mem_req, r_iord, r_alusrc, r_memread, r_memwrite,
             r_regwrite, r_memtoreg, r_busy} <= moore_ctrl(w_state_nxt, w_class_nxt);
        end
    end

    assign ir_write_o = (r_state == ST_FETCH) && mem_ready_i;
    assign pc_write_o = (r_state == ST_FETCH) && mem_ready_i;
    assign mem_req_o  = r_mem_req;
    assign iord_o     = r_iord;
    assign alusrc_o   = r_alusrc;
    assign memread_o  = r_memread;
    assign memwrite_o = r_memwrite;
    assign regwrite_o = r_regwrite;
    assign memtoreg_o = r_memtoreg;
    assign busy_o     = r_busy;
    assign illegal_o  = r_illegal;
    assign timeout_o  = r_timeout;
    assign instret_o  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model emits the expected
// per-cycle control vector, and one compare process checks the DUT on every falling edge.
module tb_multicycle_ctrl;

    localparam int TO = 16;
    localparam int CW = 4;

    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPLD = 7'b0000011;
    localparam logic [6:0] OPST = 7'b0100011;
    localparam logic [6:0] OPJAL = 7'b1101111;

    logic          clk_i = 1'b0;
    logic          rst_i, run_i, mem_ready_i;
    logic [6:0]    opcode_i;
    logic          mem_req_o, iord_o, ir_write_o, pc_write_o, alusrc_o;
    logic          memread_o, memwrite_o, regwrite_o, memtoreg_o, busy_o;
    logic          illegal_o, timeout_o;
    logic [CW-1:0] instret_o;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .opcode_i(opcode_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .iord_o(iord_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .alusrc_o(alusrc_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .regwrite_o(regwrite_o),
        .memtoreg_o(memtoreg_o), .busy_o(busy_o), .illegal_o(illegal_o),
        .timeout_o(timeout_o), .instret_o(instret_o)
    );

    typedef struct packed {
        logic       chk;
        logic [9:0] ctrl;
        logic       ill;
        logic       tmo;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int   m_instret = 0;
    bit   m_illegal = 1'b0;
    bit   m_timeout = 1'b0;
    bit   m_trapped = 1'b0;
    bit   m_reset_hit = 1'b0;

    // ctrl = {req, iord, ir_write, pc_write, alusrc, memread, memwrite, regwrite, memtoreg, busy}
    function automatic logic [9:0] ctl(input bit req, input bit iord, input bit irw, input bit pcw,
                                       input bit als, input bit mr, input bit mw, input bit rw,
                                       input bit m2r, input bit bsy);
        return {req, iord, irw, pcw, als, mr, mw, rw, m2r, bsy};
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            OPR:     return 0;
            OPI:     return 1;
            OPLD:    return 2;
            OPST:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 5) return OPR;
        else if (r < 10) return OPI;
        else if (r < 14) return OPLD;
        else if (r < 18) return OPST;
        else return rnd_op();
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return $urandom_range(0, 2);
        else if (r < 96) return $urandom_range(3, TO - 1);
        else return TO;
    endfunction

    // Compare process: one expected vector per cycle, checked mid-cycle.
    always @(negedge clk_i) begin
        exp_t        e;
        logic [15:0] act;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                act = {mem_req_o, iord_o, ir_write_o, pc_write_o, alusrc_o, memread_o,
                       memwrite_o, regwrite_o, memtoreg_o, busy_o, illegal_o, timeout_o, instret_o};
                n_vec++;
                if (act !== {e.ctrl, e.ill, e.tmo, e.cnt}) begin
                    n_err++;
                    $display("FAIL outputs cyc=%0d got=%b required=%b (req,iord,irw,pcw,als,mr,mw,rw,m2r,busy,ill,tmo,cnt)",
                             cyc, act, {e.ctrl, e.ill, e.tmo, e.cnt});
                end
            end
        end
    end

    task automatic lit(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show during that cycle.
    task automatic step(input bit rst, input bit run, input logic [6:0] op, input bit rdy,
                        input logic [9:0] ctrl, input bit chk);
        exp_t e;
        rst_i       = rst;
        run_i       = run;
        opcode_i    = op;
        mem_ready_i = rdy;
        e.chk  = chk;
        e.ctrl = ctrl;
        e.ill  = m_illegal;
        e.tmo  = m_timeout;
        e.cnt  = 4'(m_instret % 16);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        m_instret = 0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        m_trapped = 1'b0;
    endtask

    // Valid only while the FSM sits in IDLE or TRAP (all controls low).
    task automatic do_reset();
        step(1'b1, rbit(), rnd_op(), rbit(), 10'b0, 1'b1);
        model_reset();
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rbit(), rnd_op(), rbit(), 10'b0, 1'b1);
    endtask

    // One instruction, starting with the FSM in FETCH.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input bit run_last,
                            input bit rst_mem, output int ncyc);
        int cls;
        bit ld, st;
        cls = cls_of(op);
        ld  = (cls == 2);
        st  = (cls == 3);
        ncyc = 0;
        m_reset_hit = 1'b0;
        for (int i = 0; i < TO; i++) begin
            ncyc++;
            if (i == fw) begin
                step(1'b0, rbit(), rnd_op(), 1'b1, ctl(1,0,1,1,0,1,0,0,0,1), 1'b1);
                break;
            end
            step(1'b0, rbit(), rnd_op(), 1'b0, ctl(1,0,0,0,0,1,0,0,0,1), 1'b1);
            if (i == TO - 1) begin
                m_timeout = 1'b1;
                m_trapped = 1'b1;
            end
        end
        if (m_trapped) return;
        step(1'b0, rbit(), op, rbit(), ctl(0,0,0,0,0,0,0,0,0,1), 1'b1);
        ncyc++;
        if (cls == 4) begin
            m_illegal = 1'b1;
            m_trapped = 1'b1;
            return;
        end
        step(1'b0, rbit(), rnd_op(), rbit(), ctl(0,0,0,0,(cls != 0),0,0,0,0,1), 1'b1);
        ncyc++;
        if (ld || st) begin
            if (rst_mem) begin
                step(1'b1, rbit(), rnd_op(), rbit(), ctl(1,1,0,0,1,ld,st,0,0,1), 1'b1);
                model_reset();
                m_reset_hit = 1'b1;
                return;
            end
            for (int i = 0; i < TO; i++) begin
                ncyc++;
                if (i == mw) begin
                    step(1'b0, st ? run_last : rbit(), rnd_op(), 1'b1, ctl(1,1,0,0,1,ld,st,0,0,1), 1'b1);
                    break;
                end
                step(1'b0, rbit(), rnd_op(), 1'b0, ctl(1,1,0,0,1,ld,st,0,0,1), 1'b1);
                if (i == TO - 1) begin
                    m_timeout = 1'b1;
                    m_trapped = 1'b1;
                end
            end
            if (m_trapped) return;
            if (st) begin
                m_instret++;
                return;
            end
        end
        step(1'b0, run_last, rnd_op(), rbit(), ctl(0,0,0,0,0,0,0,1,ld,1), 1'b1);
        m_instret++;
        ncyc++;
    endtask

    task automatic start_run();
        step(1'b0, 1'b1, rnd_op(), rbit(), 10'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int  nc;
        bit  in_fetch;
        logic [6:0] op;
        int  fw, mw;
        bit  rl, rm;
        rst_i = 1'b1; run_i = 1'b0; opcode_i = 7'd0; mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        step(1'b1, 1'b0, 7'd0, 1'b0, 10'b0, 1'b0);
        step(1'b1, 1'b1, 7'd0, 1'b1, 10'b0, 1'b1);
        lit("reset_busy", int'(busy_o), 0);
        lit("reset_instret", int'(instret_o), 0);
        step(1'b0, 1'b0, rnd_op(), 1'b1, 10'b0, 1'b1);

        start_run();
        do_instr(OPR, 0, 0, 1'b0, 1'b0, nc);
        lit("r_latency", nc, 4);
        lit("r_instret", int'(instret_o), 1);
        start_run();
        do_instr(OPLD, 0, 2, 1'b0, 1'b0, nc);
        lit("ld_wait2_latency", nc, 7);
        start_run();
        do_instr(OPST, 0, 0, 1'b0, 1'b0, nc);
        lit("st_latency", nc, 4);
        lit("st_then_idle_busy", int'(busy_o), 0);
        lit("st_instret", int'(instret_o), 3);
        start_run();
        do_instr(OPLD, 0, 0, 1'b1, 1'b0, nc);
        lit("ld_latency", nc, 5);
        do_instr(OPI, TO - 1, 0, 1'b0, 1'b0, nc);
        lit("fetch_ready_last_no_trap", int'(timeout_o), 0);
        lit("fetch_ready_last_instret", int'(instret_o), 5);

        // 16 retires from reset wrap the 4-bit counter back to zero.
        do_reset();
        start_run();
        for (int i = 0; i < 16; i++) begin
            do_instr((i % 2 == 0) ? OPR : OPI, 0, 0, (i < 15), 1'b0, nc);
            if (i == 14) lit("wrap_pre", int'(instret_o), 15);
        end
        lit("wrap_post", int'(instret_o), 0);

        start_run();
        do_instr(OPST, 1, 0, 1'b0, 1'b1, nc);
        lit("rst_mid_mem_memwrite", int'(memwrite_o), 0);
        lit("rst_mid_mem_req", int'(mem_req_o), 0);
        step(1'b0, 1'b0, rnd_op(), rbit(), 10'b0, 1'b1);

        start_run();
        do_instr(OPJAL, 0, 0, 1'b1, 1'b0, nc);
        lit("illegal_set", int'(illegal_o), 1);
        trap_cycles(4);
        lit("illegal_sticky", int'(illegal_o), 1);
        lit("trap_no_req", int'(mem_req_o), 0);
        do_reset();
        lit("illegal_cleared", int'(illegal_o), 0);

        start_run();
        do_instr(OPR, TO, 0, 1'b1, 1'b0, nc);
        lit("fetch_timeout_cycles", nc, 16);
        lit("fetch_timeout_flag", int'(timeout_o), 1);
        trap_cycles(3);
        do_reset();

        start_run();
        do_instr(OPLD, 0, TO, 1'b1, 1'b0, nc);
        lit("mem_timeout_flag", int'(timeout_o), 1);
        trap_cycles(2);
        do_reset();

        in_fetch = 1'b0;
        repeat (250) begin
            if (!in_fetch) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rnd_op(), rbit(), 10'b0, 1'b1);
                start_run();
            end
            op = pick_op();
            fw = pick_wait();
            mw = pick_wait();
            rl = rbit();
            rm = ($urandom_range(0, 39) == 0);
            do_instr(op, fw, mw, rl, rm, nc);
            if (m_trapped) begin
                trap_cycles($urandom_range(1, 3));
                do_reset();
                in_fetch = 1'b0;
            end else if (m_reset_hit) begin
                in_fetch = 1'b0;
            end else begin
                in_fetch = rl;
            end
        end

        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
